// File: rtl/ring_generator_word_pkg.sv
// ring_gen_pkg: default constants and injection-vector builder shared by the ring generator.
package ring_gen_pkg;
    localparam logic [15:0] RG_SEED_DEFAULT    = 16'hACE1;
    localparam logic [15:0] RG_FB_MASK_DEFAULT = 16'h0068;
    localparam logic [31:0] RG_INJ_POS_DEFAULT = 32'h0E0B_0901;
    localparam int RG_MAX_W   = 64;
    localparam int RG_MAX_OSC = 8;
    // Channels sharing a position XOR together; positions are range-checked at elaboration.
    function automatic logic [RG_MAX_W-1:0] rg_inj_vec(input logic [RG_MAX_OSC-1:0] osc,
                                                      input logic [RG_MAX_OSC*8-1:0] pos,
                                                      input int n_osc);
        logic [RG_MAX_W-1:0] v;
        v = '0;
        for (int k = 0; k < RG_MAX_OSC; k++)
            if (k < n_osc) v[pos[8*k +: 6]] = v[pos[8*k +: 6]] ^ osc[k];
        return v;
    endfunction
endpackage

// File: rtl/ring_generator_word_bit_collector.sv
// bit_collector: decimates a bit stream, packs it MSB-first into words, valid/ready slot with sticky overrun.
module bit_collector #(
    parameter int OUT_W = 32,
    parameter int DECIM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clr,
    input  logic             bit_in,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun
);
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int BW = $clog2(OUT_W);
    logic [DW-1:0] dcnt;
    logic [BW-1:0] bcnt;
    logic [OUT_W-1:0] shr, nxt;
    logic sample, done, free, load;
    assign sample = step && dcnt == DW'(DECIM - 1);
    assign done   = sample && bcnt == BW'(OUT_W - 1);
    assign nxt    = {shr[OUT_W-2:0], bit_in};
    assign free   = !word_valid || word_ready;
    assign load   = done && free;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt       <= '0;
            bcnt       <= '0;
            shr        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (clr) begin
                dcnt <= '0;
                bcnt <= '0;
                shr  <= '0;
            end else if (step) begin
                dcnt <= sample ? '0 : dcnt + 1'b1;
                if (sample) begin
                    shr  <= nxt;
                    bcnt <= done ? '0 : bcnt + 1'b1;
                end
            end
            overrun    <= clr ? 1'b0 : overrun | (done && !free);
            word_valid <= load | (word_valid & !word_ready);
            if (load) word_out <= nxt;
        end
    end
endmodule

// File: rtl/ring_generator_word.sv
// ring_generator_word: oscillator-injected ring generator with seed load, enable and word collector.
module ring_generator_word
    import ring_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_OSC = 4,
    parameter logic [WIDTH-1:0] FB_MASK = WIDTH'(RG_FB_MASK_DEFAULT),
    parameter logic [N_OSC*8-1:0] INJ_POS = (N_OSC*8)'(RG_INJ_POS_DEFAULT),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(RG_SEED_DEFAULT),
    parameter int OUT_W = 32,
    parameter int DECIM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_OSC-1:0] osc_in,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic             bit_out,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun
);
    logic [WIDTH-1:0] q_reg, q_next, inj;
    logic [RG_MAX_W-1:0] inj_full;
    logic fb;
    for (genvar k = 0; k < N_OSC; k++) begin : g_pos
        if (int'(INJ_POS[8*k +: 8]) >= WIDTH) begin : g_bad
            $error("INJ_POS entry out of range");
        end
    end
    assign inj_full = rg_inj_vec(RG_MAX_OSC'(osc_in), (RG_MAX_OSC*8)'(INJ_POS), N_OSC);
    assign inj      = inj_full[WIDTH-1:0];
    assign fb       = q_reg[WIDTH-1];
    // Bit 0 of FB_MASK is ignored: position 0 always takes the feedback bit.
    assign q_next   = {q_reg[WIDTH-2:0], fb} ^ (FB_MASK & {{(WIDTH-1){fb}}, 1'b0}) ^ inj;
    assign bit_out  = fb;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= SEED;
        else if (seed_load) q_reg <= seed_val == '0 ? SEED : seed_val;
        else if (enable) q_reg <= q_next;
    end
    bit_collector #(.OUT_W(OUT_W), .DECIM(DECIM)) u_col (
        .clk        (clk),
        .rst        (rst),
        .step       (enable & ~seed_load),
        .clr        (seed_load),
        .bit_in     (fb),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun)
    );
endmodule

// File: tb/tb_ring_generator_word.sv
// tb_ring_generator_word: scoreboard bench for the default ring generator plus a DECIM=3 instance.
module tb_ring_generator_word;
    logic clk = 0;
    logic rst = 0, en = 0, sl = 0, rdy = 0;
    logic [3:0] osc = 0;
    logic [15:0] sv = 0;
    logic bit_out, word_valid, overrun;
    logic [31:0] word_out;
    logic rst2 = 0, en2 = 0, rdy2 = 0, sl2 = 0;
    logic [3:0] osc2 = 0;
    logic [15:0] sv2 = 0;
    logic bit_out2, word_valid2, overrun2;
    logic [31:0] word_out2;
    int n_vec = 0, n_bad = 0;
    logic [15:0] mq;
    logic [31:0] m_shr;
    int m_bits;
    logic m_valid, m_ovr;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    ring_generator_word u_dut (
        .clk(clk), .rst(rst), .enable(en), .osc_in(osc), .seed_load(sl), .seed_val(sv),
        .bit_out(bit_out), .word_out(word_out), .word_valid(word_valid),
        .word_ready(rdy), .overrun(overrun)
    );
    ring_generator_word #(.DECIM(3)) u_d3 (
        .clk(clk), .rst(rst2), .enable(en2), .osc_in(osc2), .seed_load(sl2), .seed_val(sv2),
        .bit_out(bit_out2), .word_out(word_out2), .word_valid(word_valid2),
        .word_ready(rdy2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr(input logic [15:0] q, input logic [3:0] o);
        logic fb;
        logic [15:0] n;
        fb = q[15];
        n = {q[14:0], fb};
        if (fb) n = n ^ 16'h0068;
        n[1]  = n[1] ^ o[0];
        n[9]  = n[9] ^ o[1];
        n[11] = n[11] ^ o[2];
        n[14] = n[14] ^ o[3];
        return n;
    endfunction

    task automatic tick();
        logic xfer, b;
        xfer = m_valid && rdy;
        if (xfer) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else chk("word", word_out, sb.pop_front());
            m_valid = 0;
        end
        if (sl) begin
            mq = sv == 0 ? 16'hACE1 : sv;
            m_bits = 0;
            m_shr = 0;
            m_ovr = 0;
        end else if (en) begin
            b = mq[15];
            mq = lfsr(mq, osc);
            m_shr = {m_shr[30:0], b};
            m_bits++;
            if (m_bits == 32) begin
                m_bits = 0;
                if (!m_valid) begin
                    m_valid = 1;
                    sb.push_back(m_shr);
                end else m_ovr = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("q", u_dut.q_reg, mq);
        chk("bit_out", bit_out, mq[15]);
        chk("valid", word_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        if (m_valid && sb.size() > 0) chk("hold", word_out, sb[0]);
    endtask

    initial begin
        logic [15:0] q2;
        logic [31:0] shr2;
        int d2, ne, found;
        #2 rst = 1; rst2 = 1;
        #1;
        chk("rst_q", u_dut.q_reg, 16'hACE1);
        chk("rst_bit", bit_out, 1);
        chk("rst_word", word_out, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        mq = 16'hACE1; m_shr = 0; m_bits = 0; m_valid = 0; m_ovr = 0;
        en = 1; rdy = 1;
        tick(); chk("t1_q1", u_dut.q_reg, 16'h59AB);
        tick(); chk("t1_q2", u_dut.q_reg, 16'hB356);
        sl = 1; sv = 16'hACE1; tick(); sl = 0;
        osc = 4'b0001; tick(); osc = 0;
        chk("t2_q", u_dut.q_reg, 16'h59A9);
        sl = 1; sv = 0; tick(); sl = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) chk("t3_early", word_valid, 0);
        end
        chk("t3_valid", word_valid, 1);
        chk("t3_msbs", word_out[31:29], 3'b101);
        tick(); chk("t3_pulse", word_valid, 0);
        sl = 1; tick(); sl = 0;
        rdy = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 63) chk("t4_ovr63", overrun, 0);
            if (i == 64) chk("t4_ovr64", overrun, 1);
        end
        rdy = 1; tick(); chk("t4_drained", word_valid, 0);
        rdy = 0;
        for (int i = 0; i < 40 && !m_valid; i++) tick();
        chk("t5_pending", word_valid, 1);
        sl = 1; sv = 0; tick(); sl = 0;
        chk("t5_q", u_dut.q_reg, 16'hACE1);
        chk("t5_valid", word_valid, 1);
        chk("t5_ovr", overrun, 0);
        chk("t5_bcnt", u_dut.u_col.bcnt, 0);
        chk("t5_dcnt", u_dut.u_col.dcnt, 0);
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 3) != 0;
            osc = 4'($urandom);
            rdy = $urandom_range(0, 2) != 0;
            sl = $urandom_range(0, 40) == 0;
            sv = $urandom_range(0, 1) ? 16'h0 : 16'($urandom);
            tick();
        end
        en = 0; sl = 0;
        rst2 = 0; q2 = 16'hACE1; shr2 = 0; d2 = 0; ne = 0; found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            en2 = c % 2 == 0;
            if (en2) begin
                ne++;
                if (d2 == 2) begin
                    shr2 = {shr2[30:0], q2[15]};
                    d2 = 0;
                end else d2++;
                q2 = lfsr(q2, 4'b0);
            end
            @(posedge clk);
            #1;
            if (word_valid2) begin
                found = 1;
                chk("d3_cnt", ne, 96);
                chk("d3_word", word_out2, shr2);
            end
        end
        if (found == 0) chk("d3_timeout", 0, 1);
        for (int c = 0; c < 10; c++) begin
            en2 = c % 2 == 0;
            @(posedge clk);
            #1;
        end
        chk("d3_held", word_valid2, 1);
        #2 rst2 = 1;
        #1;
        chk("d3_rst_valid", word_valid2, 0);
        chk("d3_rst_word", word_out2, 0);
        chk("d3_rst_ovr", overrun2, 0);
        chk("d3_rst_bit", bit_out2, 1);
        chk("d3_rst_q", u_d3.q_reg, 16'hACE1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
